fpu_result_collector: RTL and testbench
=======================================

Name: fpu_result_collector

Overview:
- Receive end of the FPU_unit result interface. Captures each FPU add/sub result (32-bit single-precision sum plus overflow and underflow flags) from a valid/ready producer.
- Buffers results in order in a first-word-fall-through FIFO. A downstream reader (scoreboard, CPU bus, or test harness) drains it through a valid/ready port.
- Keeps sticky exception status and a saturating exception counter so the flags are not lost between reads.

Parameters:
- DATA_W, 32, result width in bits; IEEE-754 single precision is fixed at 32.
- DEPTH, 8, number of FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the exception counter.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_res_valid  input  1  producer presents a result this cycle.
- o_res_ready  output  1  collector can accept a result (equals !o_full).
- i_32_s  input  DATA_W  FPU result.
- i_ov_flag  input  1  FPU overflow flag for this result.
- i_un_flag  input  1  FPU underflow flag for this result.
- i_add_sub  input  1  operation tag (0 = add, 1 = sub), stored with the result.
- o_rd_valid  output  1  head entry available (equals !o_empty).
- i_rd_ready  input  1  reader consumes the head entry.
- o_32_s  output  DATA_W  head result.
- o_ov_flag  output  1  head overflow flag.
- o_un_flag  output  1  head underflow flag.
- o_add_sub  output  1  head operation tag.
- o_is_inf  output  1  head exponent is 0xFF and mantissa is 0.
- o_is_nan  output  1  head exponent is 0xFF and mantissa is not 0.
- o_full  output  1  level equals DEPTH.
- o_empty  output  1  level equals 0.
- o_level  output  $clog2(DEPTH)+1  current entry count.
- o_sticky_ov  output  1  at least one overflow accepted since reset or clear.
- o_sticky_un  output  1  at least one underflow accepted since reset or clear.
- i_clr_sticky  input  1  clears both sticky bits.
- o_exc_cnt  output  CNT_W  count of accepted results with ov or un set.

Behaviour:
- Reset (i_rst high at a clock edge):
  - Pointers, level, sticky bits and o_exc_cnt go to 0; o_empty=1, o_full=0, o_rd_valid=0.
  - Writes and reads presented in that cycle are ignored.
  - Storage contents are don't-care. Head data outputs are don't-care while o_empty=1.
  - Reset mid-operation discards all buffered entries.
- Write: accepted when i_res_valid and o_res_ready are both high at the edge. Stores {i_add_sub, i_un_flag, i_ov_flag, i_32_s} at the write pointer, then the write pointer increments.
- Read: occurs when o_rd_valid and i_rd_ready are both high at the edge; the read pointer increments.
  - Head outputs come combinationally from the read-pointer entry (first-word fall-through).
- Latency: an entry written into an empty FIFO appears on o_32_s with o_rd_valid=1 in the cycle after the accepting edge.
- Pointers: $clog2(DEPTH)+1 bits wide (extra wrap bit); wrap naturally from DEPTH-1 to 0.
  - o_full is asserted when the addresses are equal and the wrap bits differ.
  - o_empty is asserted when the pointers are fully equal.
- Simultaneous read and write (FIFO not full, not empty): both take effect; level is unchanged; order is preserved.
- Full: o_res_ready=0, so a write is refused even when a read happens in the same cycle. The producer holds i_32_s and its flags until accepted.
- Empty: i_rd_ready is ignored; pointers and level are unchanged.
- Level: +1 on write only, -1 on read only, unchanged on both or neither.
- Sticky bits:
  - o_sticky_ov is set on an accepted write with i_ov_flag=1; o_sticky_un likewise with i_un_flag=1.
  - i_clr_sticky clears both at the edge.
  - If a clear and a set happen in the same cycle, set wins.
- o_exc_cnt: +1 per accepted write with i_ov_flag or i_un_flag high (a write with both counts once). Saturates at 2^CNT_W-1. Not affected by i_clr_sticky.
- Classifiers: o_is_inf and o_is_nan decode head bits [30:23] and [22:0]; combinational; valid only when o_rd_valid=1.

Test Plan:
- Single write: after reset, write 0x40400000 (1.0+2.0, ov=0, un=0, add) -> next cycle o_rd_valid=1, o_32_s=0x40400000, o_level=1, o_is_inf=0, o_exc_cnt=0.
- Fill/overflow: 8 writes (0x3F800000 through 0x41000000) with no reads -> o_full=1, o_res_ready=0; a held 9th value is not stored. Drain 8 entries -> values come out in write order, then o_empty=1.
- Exception: write 0x7F800000 with ov=1 -> o_sticky_ov=1, o_exc_cnt=1, and o_is_inf=1 when the entry reaches the head. Write 0x7FC00000 -> o_is_nan=1 at head.
- Sticky race: i_clr_sticky with an accepted ov=1 write in the same cycle -> o_sticky_ov stays 1. A clear alone next cycle -> o_sticky_ov=0 and o_exc_cnt is unchanged.
- Wrap plus simultaneous traffic: hold o_level=3 and perform 20 concurrent write/read cycles -> o_level stays 3 throughout; 20 outputs match the inputs in order across the pointer wrap.
- Reset mid-operation: with o_level=5 and o_sticky_un=1, assert i_rst for 1 cycle together with a write -> next cycle o_level=0, o_empty=1, sticky bits 0, o_exc_cnt=0, and no entry from the write.

Source files
------------

// File: rtl/fpu_result_collector_if.sv
// Result and read-port bundle between the FPU producer, the collector and its reader.
interface fpu_result_collector_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    // producer side
    logic              i_res_valid;
    logic              o_res_ready;
    logic [DATA_W-1:0] i_32_s;
    logic              i_ov_flag;
    logic              i_un_flag;
    logic              i_add_sub;

    // reader side
    logic              o_rd_valid;
    logic              i_rd_ready;
    logic [DATA_W-1:0] o_32_s;
    logic              o_ov_flag;
    logic              o_un_flag;
    logic              o_add_sub;
    logic              o_is_inf;
    logic              o_is_nan;

    // status
    logic              o_full;
    logic              o_empty;
    logic [LVL_W-1:0]  o_level;
    logic              o_sticky_ov;
    logic              o_sticky_un;
    logic              i_clr_sticky;
    logic [CNT_W-1:0]  o_exc_cnt;

    // driven by producer/reader/harness
    modport master (
        output i_res_valid, i_32_s, i_ov_flag, i_un_flag, i_add_sub,
        output i_rd_ready, i_clr_sticky,
        input  o_res_ready, o_rd_valid, o_32_s, o_ov_flag, o_un_flag, o_add_sub,
        input  o_is_inf, o_is_nan, o_full, o_empty, o_level,
        input  o_sticky_ov, o_sticky_un, o_exc_cnt
    );

    // the collector itself
    modport slave (
        input  i_res_valid, i_32_s, i_ov_flag, i_un_flag, i_add_sub,
        input  i_rd_ready, i_clr_sticky,
        output o_res_ready, o_rd_valid, o_32_s, o_ov_flag, o_un_flag, o_add_sub,
        output o_is_inf, o_is_nan, o_full, o_empty, o_level,
        output o_sticky_ov, o_sticky_un, o_exc_cnt
    );
endinterface

// File: rtl/fpu_result_collector.sv
// In-order FWFT buffer for FPU add/sub results with sticky exception status
// and a saturating exception counter.
module fpu_result_collector #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    fpu_result_collector_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic              add_sub;
        logic              un;
        logic              ov;
        logic [DATA_W-1:0] sum;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    level;
    logic             sticky_ov;
    logic             sticky_un;
    logic [CNT_W-1:0] exc_cnt;

    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;
    logic             exc_hit;
    entry_t           head;
    entry_t           wr_entry;

    // Full when addresses match but wrap bits differ; empty when pointers match.
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign wr_en   = bus.i_res_valid && !full;
    assign rd_en   = bus.i_rd_ready && !empty;
    assign exc_hit = wr_en && (bus.i_ov_flag || bus.i_un_flag);

    assign wr_entry = '{add_sub: bus.i_add_sub, un: bus.i_un_flag,
                        ov: bus.i_ov_flag, sum: bus.i_32_s};
    assign head     = mem[rd_ptr[AW-1:0]];

    // Storage: no reset, contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // Pointers and level; the extra pointer bit wraps naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + PW'(1);
                2'b01:   level <= level - PW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky exception bits: a set in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sticky_ov <= 1'b0;
            sticky_un <= 1'b0;
        end else begin
            sticky_ov <= (sticky_ov && !bus.i_clr_sticky) || (wr_en && bus.i_ov_flag);
            sticky_un <= (sticky_un && !bus.i_clr_sticky) || (wr_en && bus.i_un_flag);
        end
    end

    // Saturating count of accepted results carrying any exception flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            exc_cnt <= '0;
        end else if (exc_hit && (exc_cnt != {CNT_W{1'b1}})) begin
            exc_cnt <= exc_cnt + CNT_W'(1);
        end
    end

    assign bus.o_res_ready = !full;
    assign bus.o_rd_valid  = !empty;
    assign bus.o_full      = full;
    assign bus.o_empty     = empty;
    assign bus.o_level     = level;
    assign bus.o_sticky_ov = sticky_ov;
    assign bus.o_sticky_un = sticky_un;
    assign bus.o_exc_cnt   = exc_cnt;

    // First-word fall-through head and its IEEE-754 class decode.
    assign bus.o_32_s    = head.sum;
    assign bus.o_ov_flag = head.ov;
    assign bus.o_un_flag = head.un;
    assign bus.o_add_sub = head.add_sub;
    assign bus.o_is_inf  = (head.sum[30:23] == 8'hFF) && (head.sum[22:0] == 23'd0);
    assign bus.o_is_nan  = (head.sum[30:23] == 8'hFF) && (head.sum[22:0] != 23'd0);

endmodule

// File: tb/tb_fpu_result_collector.sv
// Scoreboard bench for fpu_result_collector.
module tb_fpu_result_collector;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fpu_result_collector_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    fpu_result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [34:0]      sb_q[$];
    logic             exp_sov;
    logic             exp_sun;
    logic [CNT_W-1:0] exp_cnt;

    // Timeout guard in case stimulus never completes.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] head_word();
        return {bus.o_add_sub, bus.o_un_flag, bus.o_ov_flag, bus.o_32_s};
    endfunction

    task automatic check_head(input string tag);
        if (sb_q.size() == 0) check({tag, "_sb_empty"}, 64'(bus.o_rd_valid), 64'd1);
        else check(tag, 64'(head_word()), 64'(sb_q[0]));
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"}, 64'(bus.o_level), 64'(sb_q.size()));
        check({tag, "_sov"},   64'(bus.o_sticky_ov), 64'(exp_sov));
        check({tag, "_sun"},   64'(bus.o_sticky_un), 64'(exp_sun));
        check({tag, "_cnt"},   64'(bus.o_exc_cnt), 64'(exp_cnt));
    endtask

    // One clock: update the model from the pre-edge handshake, then advance.
    task automatic step();
        logic wr;
        if (rst) begin
            sb_q.delete();
            exp_sov = 1'b0;
            exp_sun = 1'b0;
            exp_cnt = '0;
        end else begin
            wr = bus.i_res_valid && (sb_q.size() < DEPTH);
            if (bus.o_rd_valid && bus.i_rd_ready) begin
                check_head("pop");
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end
            if (wr) begin
                sb_q.push_back({bus.i_add_sub, bus.i_un_flag, bus.i_ov_flag, bus.i_32_s});
                if ((bus.i_ov_flag || bus.i_un_flag) && exp_cnt != {CNT_W{1'b1}})
                    exp_cnt = exp_cnt + CNT_W'(1);
            end
            exp_sov = (exp_sov && !bus.i_clr_sticky) || (wr && bus.i_ov_flag);
            exp_sun = (exp_sun && !bus.i_clr_sticky) || (wr && bus.i_un_flag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [31:0] d, input logic ov, input logic un, input logic as);
        bus.i_res_valid = 1'b1;
        bus.i_32_s      = d;
        bus.i_ov_flag   = ov;
        bus.i_un_flag   = un;
        bus.i_add_sub   = as;
    endtask

    task automatic write_one(input logic [31:0] d, input logic ov, input logic un, input logic as);
        drive_wr(d, ov, un, as);
        step();
        bus.i_res_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.i_rd_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH && bus.o_rd_valid; i++) step();
        bus.i_rd_ready = 1'b0;
        check({tag, "_empty"}, 64'(bus.o_empty), 64'd1);
        check({tag, "_sb_size"}, 64'(sb_q.size()), 64'd0);
    endtask

    logic [31:0] fill_vals [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                   32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    initial begin
        bus.i_res_valid  = 1'b0;
        bus.i_32_s       = '0;
        bus.i_ov_flag    = 1'b0;
        bus.i_un_flag    = 1'b0;
        bus.i_add_sub    = 1'b0;
        bus.i_rd_ready   = 1'b0;
        bus.i_clr_sticky = 1'b0;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_empty", 64'(bus.o_empty), 64'd1);
        check("rst_full", 64'(bus.o_full), 64'd0);
        check("rst_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        check("rst_res_ready", 64'(bus.o_res_ready), 64'd1);
        check_status("rst");

        // Single write appears on the head the next cycle
        write_one(32'h40400000, 1'b0, 1'b0, 1'b0);
        check("single_rd_valid", 64'(bus.o_rd_valid), 64'd1);
        check("single_data", 64'(bus.o_32_s), 64'h40400000);
        check("single_is_inf", 64'(bus.o_is_inf), 64'd0);
        check_head("single_head");
        check_status("single");
        drain("single");

        // Fill to full, hold a refused 9th write, then drain in order
        foreach (fill_vals[i]) write_one(fill_vals[i], 1'b0, 1'b0, i[0]);
        check("fill_full", 64'(bus.o_full), 64'd1);
        check("fill_ready", 64'(bus.o_res_ready), 64'd0);
        drive_wr(32'h41100000, 1'b1, 1'b0, 1'b0);
        step();
        step();
        bus.i_res_valid = 1'b0;
        check_status("fill_held");
        drain("fill");

        // Exception results and classifiers
        write_one(32'h7F800000, 1'b1, 1'b0, 1'b0);
        check("inf_is_inf", 64'(bus.o_is_inf), 64'd1);
        check("inf_is_nan", 64'(bus.o_is_nan), 64'd0);
        check("inf_sov_const", 64'(bus.o_sticky_ov), 64'd1);
        check("inf_cnt_const", 64'(bus.o_exc_cnt), 64'd1);
        check_status("inf");
        drain("inf");
        write_one(32'h7FC00000, 1'b0, 1'b0, 1'b1);
        check("nan_is_nan", 64'(bus.o_is_nan), 64'd1);
        check("nan_is_inf", 64'(bus.o_is_inf), 64'd0);
        drain("nan");

        // Clear and set in the same cycle: set wins; then clear alone
        bus.i_clr_sticky = 1'b1;
        write_one(32'h7F800000, 1'b1, 1'b1, 1'b0);
        check("race_sov", 64'(bus.o_sticky_ov), 64'd1);
        check_status("race");
        step();
        bus.i_clr_sticky = 1'b0;
        check("clr_sov", 64'(bus.o_sticky_ov), 64'd0);
        check("clr_cnt", 64'(bus.o_exc_cnt), 64'd2);
        check_status("clr");
        drain("race");

        // Hold level 3 through 20 concurrent write/read cycles across the wrap
        for (int i = 0; i < 3; i++) write_one(32'h3F000000 + 32'(i), 1'b0, 1'b0, 1'b0);
        bus.i_rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_wr($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            step();
            check("wrap_level", 64'(bus.o_level), 64'd3);
        end
        bus.i_res_valid = 1'b0;
        bus.i_rd_ready  = 1'b0;
        check_status("wrap");
        drain("wrap");

        // Reset mid-operation discards entries and the concurrent write
        exp_cnt = bus.o_exc_cnt;
        for (int i = 0; i < 5; i++) write_one(32'h40000000 + 32'(i), 1'b0, (i == 2), 1'b0);
        check_status("pre_rst");
        drive_wr(32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_res_valid = 1'b0;
        check("mid_rst_empty", 64'(bus.o_empty), 64'd1);
        check("mid_rst_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        check_status("mid_rst");
        write_one(32'h12345678, 1'b0, 1'b0, 1'b1);
        check_head("post_rst_head");
        check_status("post_rst");
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
